// File: rtl/pipelined_core.sv
// Five-stage in-order integer pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB, register write)
// with full operand forwarding, a valid/ready instruction handshake and a global stall.
module pipelined_core #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 2,
  parameter int CNT_W  = 16,
  localparam int INSTR_W  = 4 + 2 * REG_AW,
  localparam int NUM_REGS = 2 ** REG_AW
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic               stall,
  output logic               wb_valid,
  output logic [REG_AW-1:0]  wb_addr,
  output logic [DATA_W-1:0]  wb_data,
  input  logic [REG_AW-1:0]  dbg_addr,
  output logic [DATA_W-1:0]  dbg_data,
  output logic [CNT_W-1:0]   retire_count
);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_INC = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_MOV = 3'b111;

  function automatic logic [DATA_W-1:0] alu(input logic [2:0] op,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
    case (op)
      OP_ADD:  alu = a + b;
      OP_SUB:  alu = a - b;
      OP_INC:  alu = a + DATA_W'(1);
      OP_AND:  alu = a & b;
      OP_OR:   alu = a | b;
      OP_XOR:  alu = a ^ b;
      OP_MOV:  alu = b;
      default: alu = '0;
    endcase
  endfunction

  logic                ifid_vld_q, ifid_vld_d;
  logic [INSTR_W-1:0]  ifid_instr_q, ifid_instr_d;
  logic                idex_wr_q, idex_wr_d;
  logic                idex_imm_q, idex_imm_d;
  logic [2:0]          idex_op_q, idex_op_d;
  logic [REG_AW-1:0]   idex_rd_q, idex_rd_d;
  logic [REG_AW-1:0]   idex_rs_q, idex_rs_d;
  logic [DATA_W-1:0]   idex_a_q, idex_a_d;
  logic [DATA_W-1:0]   idex_b_q, idex_b_d;
  logic                exmem_wr_q, exmem_wr_d;
  logic [REG_AW-1:0]   exmem_rd_q, exmem_rd_d;
  logic [DATA_W-1:0]   exmem_res_q, exmem_res_d;
  logic                memwb_wr_q, memwb_wr_d;
  logic [REG_AW-1:0]   memwb_rd_q, memwb_rd_d;
  logic [DATA_W-1:0]   memwb_res_q, memwb_res_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [CNT_W-1:0]    retire_q, retire_d;

  logic                id_mode;
  logic [2:0]          id_op;
  logic [REG_AW-1:0]   id_rd, id_rs;
  logic [DATA_W-1:0]   id_a, id_b;
  logic [DATA_W-1:0]   ex_a, ex_b, ex_res;

  // ID: field decode and register read with write-through bypass from MEM/WB
  assign id_mode = ifid_instr_q[INSTR_W-1];
  assign id_op   = ifid_instr_q[INSTR_W-2 -: 3];
  assign id_rd   = ifid_instr_q[2*REG_AW-1 -: REG_AW];
  assign id_rs   = ifid_instr_q[REG_AW-1:0];
  assign id_a = (memwb_wr_q && memwb_rd_q == id_rd) ? memwb_res_q : regs_q[id_rd];
  assign id_b = id_mode ? DATA_W'(id_rs)
              : (memwb_wr_q && memwb_rd_q == id_rs) ? memwb_res_q : regs_q[id_rs];

  // EX: per-operand forwarding, newest producer first; immediates bypass it
  assign ex_a = (exmem_wr_q && exmem_rd_q == idex_rd_q) ? exmem_res_q
              : (memwb_wr_q && memwb_rd_q == idex_rd_q) ? memwb_res_q : idex_a_q;
  assign ex_b = idex_imm_q ? idex_b_q
              : (exmem_wr_q && exmem_rd_q == idex_rs_q) ? exmem_res_q
              : (memwb_wr_q && memwb_rd_q == idex_rs_q) ? memwb_res_q : idex_b_q;
  assign ex_res = alu(idex_op_q, ex_a, ex_b);

  always_comb begin
    ifid_vld_d   = ifid_vld_q;
    ifid_instr_d = ifid_instr_q;
    idex_wr_d    = idex_wr_q;
    idex_imm_d   = idex_imm_q;
    idex_op_d    = idex_op_q;
    idex_rd_d    = idex_rd_q;
    idex_rs_d    = idex_rs_q;
    idex_a_d     = idex_a_q;
    idex_b_d     = idex_b_q;
    exmem_wr_d   = exmem_wr_q;
    exmem_rd_d   = exmem_rd_q;
    exmem_res_d  = exmem_res_q;
    memwb_wr_d   = memwb_wr_q;
    memwb_rd_d   = memwb_rd_q;
    memwb_res_d  = memwb_res_q;
    regs_d       = regs_q;
    retire_d     = retire_q;
    if (!stall) begin
      ifid_vld_d   = instr_valid;
      ifid_instr_d = instr;
      idex_wr_d    = ifid_vld_q && (id_op != OP_NOP);
      idex_imm_d   = id_mode;
      idex_op_d    = id_op;
      idex_rd_d    = id_rd;
      idex_rs_d    = id_rs;
      idex_a_d     = id_a;
      idex_b_d     = id_b;
      exmem_wr_d   = idex_wr_q;
      exmem_rd_d   = idex_rd_q;
      exmem_res_d  = ex_res;
      memwb_wr_d   = exmem_wr_q;
      memwb_rd_d   = exmem_rd_q;
      memwb_res_d  = exmem_res_q;
      if (memwb_wr_q) begin
        regs_d[memwb_rd_q] = memwb_res_q;
        retire_d           = retire_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ifid_vld_q   <= 1'b0;
      ifid_instr_q <= '0;
      idex_wr_q    <= 1'b0;
      idex_imm_q   <= 1'b0;
      idex_op_q    <= '0;
      idex_rd_q    <= '0;
      idex_rs_q    <= '0;
      idex_a_q     <= '0;
      idex_b_q     <= '0;
      exmem_wr_q   <= 1'b0;
      exmem_rd_q   <= '0;
      exmem_res_q  <= '0;
      memwb_wr_q   <= 1'b0;
      memwb_rd_q   <= '0;
      memwb_res_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      retire_q     <= '0;
    end else begin
      ifid_vld_q   <= ifid_vld_d;
      ifid_instr_q <= ifid_instr_d;
      idex_wr_q    <= idex_wr_d;
      idex_imm_q   <= idex_imm_d;
      idex_op_q    <= idex_op_d;
      idex_rd_q    <= idex_rd_d;
      idex_rs_q    <= idex_rs_d;
      idex_a_q     <= idex_a_d;
      idex_b_q     <= idex_b_d;
      exmem_wr_q   <= exmem_wr_d;
      exmem_rd_q   <= exmem_rd_d;
      exmem_res_q  <= exmem_res_d;
      memwb_wr_q   <= memwb_wr_d;
      memwb_rd_q   <= memwb_rd_d;
      memwb_res_q  <= memwb_res_d;
      regs_q       <= regs_d;
      retire_q     <= retire_d;
    end
  end

  assign instr_ready  = !stall;
  assign wb_valid     = memwb_wr_q;
  assign wb_addr      = memwb_rd_q;
  assign wb_data      = memwb_res_q;
  assign dbg_data     = regs_q[dbg_addr];
  assign retire_count = retire_q;

endmodule
